// File: rtl/bus_mem_pkg.sv
// bus_mem_pkg: shared types and helpers for the memory responder.
// State enum, access-size masks and lane helpers.
package bus_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  localparam int BUS_DATA_W = 64;
  localparam int BUS_ADDR_W = 64;
  localparam logic [63:0] BUS_BASE_ADDR = 64'h8000_0000;

  // size mask shifted to its offset spills out of the doubleword
  function automatic logic lane_ovf(
    input logic [7:0] mask,
    input logic [2:0] off
  );
    return (16'(mask) << off) > 16'h00FF;
  endfunction

  // one mask bit per byte -> 0x00/0xFF per byte
  function automatic logic [63:0] byte_expand(
    input logic [7:0] mask
  );
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      e[8*i +: 8] = {8{mask[i]}};
    end
    return e;
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// bus_mem_array: DEPTH x 64 storage, byte write enables.
// Single port; read data registered on the same access edge.
module bus_mem_array
  import bus_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [7:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // one access per enable: masked byte write, old word to rdata
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: cycle-accurate memory slave for the core.
// Accept, wait LATENCY cycles, access array, hold response.
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_W,
  parameter int ADDR_WIDTH = BUS_ADDR_W,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR =
    ADDR_WIDTH'(BUS_BASE_ADDR),
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [7:0]            req_mask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] END_ADDR =
    BASE_ADDR + ADDR_WIDTH'(DEPTH * 8);

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [7:0]            mask_q;

  logic                  a_wen;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [7:0]            a_mask;
  logic [ADDR_WIDTH-1:0] a_rel;
  logic [7:0]            a_lane;
  logic                  a_err;
  logic                  q_err;

  logic          mem_en;
  logic [7:0]    mem_we;
  logic [AW-1:0] mem_idx;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;

  // state, counter and request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (req_valid && req_ready) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mask_q  <= req_mask;
      end
    end
  end

  // next state and handshake outputs
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY > 1) begin
            state_nx = WAIT;
            cnt_nx   = CW'(LATENCY - 1);
          end else begin
            state_nx = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          state_nx = RESP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // access fields: live inputs when LATENCY=1 skips the latch
  always_comb begin
    if (state == IDLE) begin
      a_wen   = req_wen;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_mask  = req_mask;
    end else begin
      a_wen   = wen_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_mask  = mask_q;
    end
  end

  assign a_rel  = a_addr - BASE_ADDR;
  assign a_lane = a_mask << a_addr[2:0];
  assign a_err  = (a_addr < BASE_ADDR)
               || (a_addr >= END_ADDR)
               || lane_ovf(a_mask, a_addr[2:0]);

  assign q_err  = (addr_q < BASE_ADDR)
               || (addr_q >= END_ADDR)
               || lane_ovf(mask_q, addr_q[2:0]);

  // access fires once, on the edge entering RESP
  assign mem_en = !rst && !a_err
               && (state != RESP) && (state_nx == RESP);
  assign mem_we    = a_wen ? a_lane : 8'h00;
  assign mem_idx   = AW'(a_rel >> 3);
  assign mem_wdata = 64'(a_wdata) << {a_addr[2:0], 3'b000};

  bus_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign resp_err = (state == RESP) && q_err;

  assign resp_rdata =
    (state == RESP && !wen_q && !q_err)
      ? DATA_WIDTH'((mem_rdata >> {addr_q[2:0], 3'b000})
                    & byte_expand(mask_q))
      : '0;

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: directed table, corner sequences and
// a random stream against a byte-addressed model.
module tb_bus_mem_responder;
  import bus_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req_valid  = '0;
  logic [2:0] resp_ready = '0;
  logic [2:0] req_ready, resp_valid, resp_err;
  logic        req_wen   = 1'b0;
  logic [63:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_mask  = '0;
  logic [63:0] rdata [3];

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [3][64];
  logic [7:0] mk  [4];

  typedef struct {
    bit          wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic [63:0] exp_rd;
    bit          exp_er;
  } vec_t;

  vec_t tbl [18];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_mem_responder #(
      .LATENCY (g == 0 ? 1 : (g == 1 ? 4 : 3))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_mask   (req_mask),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 4 : 3);
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_req(
    input int u,
    input bit wen,
    input logic [63:0] a,
    input logic [63:0] wd,
    input logic [7:0] m,
    input int hold,
    input logic [63:0] exp_rd,
    input bit exp_er,
    input string nm
  );
    int lat;
    int n;
    bit hold_bad;
    logic [63:0] rd;
    logic er;
    n = 0;
    @(negedge clk);
    while (!req_ready[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[u]) begin
      chk({nm, " ready"}, 64'(req_ready[u]), 64'd1);
      return;
    end
    req_valid[u] = 1'b1;
    req_wen   = wen;
    req_addr  = a;
    req_wdata = wd;
    req_mask  = m;
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
    req_wen   = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_mask  = 8'($urandom);
    lat = 0;
    hold_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready[u]) hold_bad = 1'b1;
    end while (!resp_valid[u] && lat < 40);
    chk({nm, " lat"}, 64'(lat), 64'(lat_of(u)));
    if (!resp_valid[u]) return;
    rd = rdata[u];
    er = resp_err[u];
    chk({nm, " rdata"}, rd, exp_rd);
    chk({nm, " err"}, 64'(er), 64'(exp_er));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!resp_valid[u] || rdata[u] !== rd
          || resp_err[u] !== er || req_ready[u])
        hold_bad = 1'b1;
    end
    chk({nm, " hold"}, 64'(hold_bad), 64'd0);
    resp_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[u] = 1'b0;
  endtask

  // model: bytes of window 0x8000_0100..0x8000_013F per DUT
  task automatic rand_one(input int u);
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] exp;
    int r, msel, sz, off, o;
    bit wen, er, outr;
    r = $urandom_range(0, 15);
    if (r == 0)
      a = 64'h7FFF_FFF8 + 64'($urandom_range(0, 7));
    else if (r == 1)
      a = 64'h8000_8000 + 64'($urandom_range(0, 7));
    else
      a = 64'h8000_0100 + 64'($urandom_range(0, 63));
    msel = $urandom_range(0, 3);
    sz   = 1 << msel;
    off  = int'(a % 8);
    wen  = 1'($urandom);
    wd   = {$urandom, $urandom};
    outr = (a < 64'h8000_0000) || (a >= 64'h8000_8000);
    er   = outr || (off + sz > 8);
    exp  = '0;
    if (!er) begin
      o = int'(a - 64'h8000_0100);
      for (int i = 0; i < sz; i++) begin
        if (wen) mdl[u][o+i] = wd[8*i +: 8];
        else     exp[8*i +: 8] = mdl[u][o+i];
      end
    end
    do_req(u, wen, a, wd, mk[msel],
           $urandom_range(0, 3), exp, er, "rnd");
  endtask

  initial begin : main
    bit sbad;
    logic [63:0] wd;
    mk[0] = MASK_B;
    mk[1] = MASK_H;
    mk[2] = MASK_W;
    mk[3] = MASK_D;

    tbl[0]  = '{1, 64'h8000_0000, 64'h1122334455667788, MASK_D, 64'h0, 0};
    tbl[1]  = '{0, 64'h8000_0000, 64'h0, MASK_D, 64'h1122334455667788, 0};
    tbl[2]  = '{1, 64'h8000_0003, 64'hAB, MASK_B, 64'h0, 0};
    tbl[3]  = '{0, 64'h8000_0000, 64'h0, MASK_D, 64'h11223344AB667788, 0};
    tbl[4]  = '{0, 64'h8000_0002, 64'h0, MASK_H, 64'h000000000000AB66, 0};
    tbl[5]  = '{0, 64'h7FFF_FFF8, 64'h0, MASK_D, 64'h0, 1};
    tbl[6]  = '{0, 64'h8000_0006, 64'h0, MASK_W, 64'h0, 1};
    tbl[7]  = '{1, 64'h8000_0006, 64'hDEADBEEF, MASK_W, 64'h0, 1};
    tbl[8]  = '{0, 64'h8000_0000, 64'h0, MASK_D, 64'h11223344AB667788, 0};
    tbl[9]  = '{1, 64'h8000_7FFF, 64'h5A, MASK_B, 64'h0, 0};
    tbl[10] = '{0, 64'h8000_7FFF, 64'h0, MASK_B, 64'h5A, 0};
    tbl[11] = '{0, 64'h8000_8000, 64'h0, MASK_B, 64'h0, 1};
    tbl[12] = '{1, 64'h8000_0004, 64'hCAFEBABE, MASK_W, 64'h0, 0};
    tbl[13] = '{1, 64'h8000_0001, 64'hFFFFFFFFFFFFFF12, MASK_B, 64'h0, 0};
    tbl[14] = '{0, 64'h8000_0000, 64'h0, MASK_D, 64'hCAFEBABEAB661288, 0};
    tbl[15] = '{0, 64'h8000_0007, 64'h0, MASK_H, 64'h0, 1};
    tbl[16] = '{0, 64'h8000_0006, 64'h0, MASK_H, 64'h000000000000CAFE, 0};
    tbl[17] = '{1, 64'h8000_7FFC, 64'h0, MASK_D, 64'h0, 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst ready", 64'(req_ready[u]), 64'd1);
      chk("rst valid", 64'(resp_valid[u]), 64'd0);
      chk("rst rdata", rdata[u], 64'd0);
      chk("rst err", 64'(resp_err[u]), 64'd0);
    end

    for (int i = 0; i < 18; i++) begin
      do_req(0, tbl[i].wen, tbl[i].addr, tbl[i].wdata,
             tbl[i].mask, 0, tbl[i].exp_rd, tbl[i].exp_er,
             $sformatf("vec%0d", i));
    end

    do_req(1, 1, 64'h8000_0010, 64'h0123456789ABCDEF,
           MASK_D, 0, 64'h0, 0, "l4 wr");
    do_req(1, 0, 64'h8000_0010, 64'h0, MASK_D, 3,
           64'h0123456789ABCDEF, 0, "l4 rd bp");
    do_req(1, 1, 64'h8000_0014, 64'h77, MASK_B, 3,
           64'h0, 0, "l4 wr bp");
    do_req(1, 0, 64'h8000_0010, 64'h0, MASK_D, 0,
           64'h0123457789ABCDEF, 0, "l4 rd2");

    do_req(2, 1, 64'h8000_0020, 64'h5555555555555555,
           MASK_D, 0, 64'h0, 0, "l3 wr");
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 64'h8000_0020;
    req_wdata = 64'hAAAAAAAAAAAAAAAA;
    req_mask  = MASK_D;
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("wrst ready", 64'(req_ready[2]), 64'd1);
    chk("wrst valid", 64'(resp_valid[2]), 64'd0);
    chk("wrst rdata", rdata[2], 64'd0);
    chk("wrst err", 64'(resp_err[2]), 64'd0);
    sbad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid[2]) sbad = 1'b1;
    end
    chk("wrst stale", 64'(sbad), 64'd0);
    do_req(2, 0, 64'h8000_0020, 64'h0, MASK_D, 0,
           64'h5555555555555555, 0, "wrst rd");

    foreach (mk[u]) begin
      if (u == 0 || u == 2) begin
        for (int w = 0; w < 8; w++) begin
          wd = {$urandom, $urandom};
          for (int b = 0; b < 8; b++) mdl[u][8*w+b] = wd[8*b +: 8];
          do_req(u, 1, 64'h8000_0100 + 64'(8*w), wd,
                 MASK_D, 0, 64'h0, 0, "pre");
        end
        repeat (500) rand_one(u);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
